// File: rtl/dds_lut_pkg.sv
// ============================================================================
// Module      : dds_lut_pkg
// Description : Shared mode encodings, output format constants and parameter
//               legality check for the multi-channel DDS quarter-wave lookup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dds_lut_pkg;

    localparam logic [1:0] MODE_SIN = 2'd0;
    localparam logic [1:0] MODE_COS = 2'd1;
    localparam logic [1:0] MODE_RAW = 2'd2;

    localparam int OUT_W   = 32;
    localparam int GUARD_W = 4;

    function automatic bit params_legal(input int nch, input int addr_w,
                                        input int phase_w, input int data_w);
        return (nch >= 2) && (addr_w >= 1) && (phase_w == addr_w + 2) &&
               (data_w >= 1) && (data_w <= OUT_W - GUARD_W);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dds_rr_arbiter.sv
// ============================================================================
// Module      : dds_rr_arbiter
// Description : NCH-way round-robin arbiter, combinational one-hot grant and
//               a registered pointer that moves just past the last winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_rr_arbiter #(
    parameter int NCH  = 4,
    parameter int CH_W = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  i_req,
    output logic [NCH-1:0]  o_grant,
    output logic [CH_W-1:0] o_grant_idx,
    output logic            o_grant_any
);

    logic [CH_W-1:0] r_ptr;
    logic [CH_W-1:0] w_idx;
    logic            w_any;

    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= NCH) s = s - NCH;
        return CH_W'(s);
    endfunction

    always_comb begin
        w_idx   = '0;
        w_any   = 1'b0;
        o_grant = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_any && i_req[wrap_idx(r_ptr, k)]) begin
                w_any = 1'b1;
                w_idx = wrap_idx(r_ptr, k);
            end
        end
        o_grant[w_idx] = w_any;
    end

    assign o_grant_idx = w_idx;
    assign o_grant_any = w_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_idx == CH_W'(NCH - 1)) ? '0 : w_idx + CH_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dds_quad_lut.sv
// ============================================================================
// Module      : dds_quad_lut
// Description : Time-multiplexed quarter-wave sine/cosine lookup; arbitrates
//               channels onto one ROM and returns signed, tagged samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_quad_lut
    import dds_lut_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int ADDR_W  = 11,
    parameter int PHASE_W = 13,
    parameter int DATA_W  = 24,
    parameter int CH_W    = $clog2(NCH)
) (
    input  logic                   Fg_CLK,
    input  logic                   RESET,
    input  logic [NCH-1:0]         req_valid,
    input  logic [NCH*PHASE_W-1:0] req_phase,
    input  logic [NCH*2-1:0]       req_mode,
    output logic [NCH-1:0]         req_ready,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic                   rom_ce,
    input  logic [DATA_W-1:0]      rom_dout,
    output logic                   out_valid,
    output logic [CH_W-1:0]        out_ch,
    output logic [31:0]            out_data
);

    localparam int                 c_PAD_W   = OUT_W - GUARD_W - DATA_W;
    localparam logic [PHASE_W-1:0] c_QUARTER = {2'b01, {ADDR_W{1'b0}}};

    generate
        if (!params_legal(NCH, ADDR_W, PHASE_W, DATA_W)) begin : g_param_check
            $error("dds_quad_lut: illegal parameter combination");
        end
    endgenerate

    logic [CH_W-1:0]    w_gnt_idx;
    logic               w_accept;
    logic [PHASE_W-1:0] w_phase;
    logic [PHASE_W-1:0] w_phase_eff;
    logic [1:0]         w_mode;
    logic [1:0]         w_quad;
    logic [ADDR_W-1:0]  w_idx;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_neg;
    logic [OUT_W-1:0]   w_mag;

    logic [CH_W-1:0]    r_s1_ch;
    logic               r_s1_neg;
    logic               r_s2_valid;
    logic [CH_W-1:0]    r_s2_ch;
    logic               r_s2_neg;

    dds_rr_arbiter #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_arb (
        .clk         (Fg_CLK),
        .rst         (RESET),
        .i_req       (req_valid),
        .o_grant     (req_ready),
        .o_grant_idx (w_gnt_idx),
        .o_grant_any (w_accept)
    );

    // Cosine is sine advanced a quarter turn; odd quadrants mirror the index.
    always_comb begin
        w_phase     = req_phase[w_gnt_idx*PHASE_W +: PHASE_W];
        w_mode      = req_mode[w_gnt_idx*2 +: 2];
        w_phase_eff = (w_mode == MODE_COS) ? w_phase + c_QUARTER : w_phase;
        w_quad      = w_phase_eff[PHASE_W-1 -: 2];
        w_idx       = w_phase_eff[ADDR_W-1:0];
        w_addr      = w_phase[ADDR_W-1:0];
        w_neg       = 1'b0;
        if (w_mode == MODE_SIN || w_mode == MODE_COS) begin
            w_addr = w_quad[0] ? ~w_idx : w_idx;
            w_neg  = w_quad[1];
        end
    end

    assign w_mag = {{(OUT_W - DATA_W){1'b0}}, rom_dout} << c_PAD_W;

    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            rom_addr   <= '0;
            rom_ce     <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_neg   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_ch    <= '0;
            r_s2_neg   <= 1'b0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_data   <= '0;
        end else begin
            rom_ce <= w_accept;
            if (w_accept) begin
                rom_addr <= w_addr;
                r_s1_ch  <= w_gnt_idx;
                r_s1_neg <= w_neg;
            end
            r_s2_valid <= rom_ce;
            r_s2_ch    <= r_s1_ch;
            r_s2_neg   <= r_s1_neg;
            out_valid  <= r_s2_valid;
            if (r_s2_valid) begin
                out_ch   <= r_s2_ch;
                out_data <= r_s2_neg ? -w_mag : w_mag;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dds_quad_lut.sv
// ============================================================================
// Module      : tb_dds_quad_lut
// Description : Self-checking bench for dds_quad_lut with an arithmetic
//               reference model and a ROM returning rom[k] = k + 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_quad_lut;

    localparam int NCH     = 4;
    localparam int ADDR_W  = 11;
    localparam int PHASE_W = 13;
    localparam int DATA_W  = 24;
    localparam int CH_W    = 2;

    typedef struct {
        int          due;
        int          ch;
        logic [31:0] data;
    } exp_t;

    logic                   Fg_CLK = 1'b0;
    logic                   RESET;
    logic [NCH-1:0]         req_valid;
    logic [NCH*PHASE_W-1:0] req_phase;
    logic [NCH*2-1:0]       req_mode;
    logic [NCH-1:0]         req_ready;
    logic [ADDR_W-1:0]      rom_addr;
    logic                   rom_ce;
    logic [DATA_W-1:0]      rom_dout = '0;
    logic                   out_valid;
    logic [CH_W-1:0]        out_ch;
    logic [31:0]            out_data;

    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          m_ptr      = 0;
    int          last_ch    = 0;
    logic [31:0] last_data  = '0;
    exp_t        sb[$];

    dds_quad_lut #(
        .NCH     (NCH),
        .ADDR_W  (ADDR_W),
        .PHASE_W (PHASE_W),
        .DATA_W  (DATA_W),
        .CH_W    (CH_W)
    ) dut (
        .Fg_CLK    (Fg_CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_phase (req_phase),
        .req_mode  (req_mode),
        .req_ready (req_ready),
        .rom_addr  (rom_addr),
        .rom_ce    (rom_ce),
        .rom_dout  (rom_dout),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    always @(posedge Fg_CLK) begin
        if (rom_ce) rom_dout <= DATA_W'(int'(rom_addr) + 1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: quarter-wave symmetry written as plain integer arithmetic.
    task automatic model(input logic [PHASE_W-1:0] ph, input logic [1:0] md,
                         output int addr, output logic [31:0] data);
        int p, q, i, mag;
        bit neg;
        p = int'(ph);
        if (md == 2'd1) p = (p + 2048) % 8192;
        q = p / 2048;
        i = p % 2048;
        if (md >= 2'd2) begin
            addr = int'(ph) % 2048;
            neg  = 1'b0;
        end else begin
            addr = (q % 2 == 1) ? 2047 - i : i;
            neg  = (q >= 2);
        end
        mag  = (addr + 1) * 16;
        data = neg ? 32'(-mag) : 32'(mag);
    endtask

    task automatic cycle();
        int          g;
        int          addr;
        logic [31:0] d;
        exp_t        e;
        #1;
        g    = -1;
        addr = 0;
        d    = '0;
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_ptr + k) % NCH;
            if (g < 0 && req_valid[c]) g = c;
        end
        chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) model(req_phase[g*PHASE_W +: PHASE_W], req_mode[g*2 +: 2], addr, d);
        @(posedge Fg_CLK);
        #1;
        cyc++;
        chk("rom_ce", 32'(rom_ce), 32'(g >= 0));
        if (g >= 0) begin
            chk("rom_addr", 32'(rom_addr), 32'(addr));
            sb.push_back('{cyc + 2, g, d});
            m_ptr = (g + 1) % NCH;
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_ch", 32'(out_ch), 32'(e.ch));
            chk("out_data", out_data, e.data);
            last_ch   = e.ch;
            last_data = e.data;
        end else begin
            chk("out_valid_idle", 32'(out_valid), 32'd0);
            chk("out_ch_hold", 32'(out_ch), 32'(last_ch));
            chk("out_data_hold", out_data, last_data);
        end
    endtask

    task automatic put(input int ch, input logic [PHASE_W-1:0] ph, input logic [1:0] md);
        req_valid                         = '0;
        req_valid[ch]                     = 1'b1;
        req_phase[ch*PHASE_W +: PHASE_W]  = ph;
        req_mode[ch*2 +: 2]               = md;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) cycle();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rom_addr"},  32'(rom_addr),  32'd0);
        chk({tag, "_rom_ce"},    32'(rom_ce),    32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_ch"},    32'(out_ch),    32'd0);
        chk({tag, "_out_data"},  out_data,       32'd0);
    endtask

    task automatic reset_pulse();
        RESET = 1'b1;
        #1;
        check_reset_state("rst_mid");
        repeat (2) @(posedge Fg_CLK);
        #1;
        RESET = 1'b0;
        cyc   = cyc + 2;
        sb.delete();
        m_ptr     = 0;
        last_ch   = 0;
        last_data = '0;
        check_reset_state("rst_rel");
    endtask

    initial begin
        RESET     = 1'b1;
        req_valid = '0;
        req_phase = '0;
        req_mode  = '0;
        repeat (2) @(posedge Fg_CLK);
        #1;
        check_reset_state("rst_init");
        RESET = 1'b0;

        put(0, 13'h0000, 2'd0); cycle(); idle(3);

        put(1, 13'h0800, 2'd0); cycle();
        put(1, 13'h1000, 2'd0); cycle(); idle(3);

        put(2, 13'h0000, 2'd1); cycle();
        put(2, 13'h1800, 2'd1); cycle(); idle(3);

        req_valid = '1;
        for (int c = 0; c < NCH; c++) begin
            req_phase[c*PHASE_W +: PHASE_W] = PHASE_W'($urandom);
            req_mode[c*2 +: 2]              = 2'($urandom_range(0, 1));
        end
        repeat (8) cycle();
        idle(3);

        put(3, 13'h1ABC, 2'd2); cycle(); idle(3);

        put(1, 13'h0123, 2'd0); cycle();
        put(2, 13'h0456, 2'd1); cycle();
        reset_pulse();
        idle(3);
        req_valid = '1;
        repeat (4) cycle();
        idle(3);

        repeat (300) begin
            req_valid = NCH'($urandom);
            req_phase = (NCH*PHASE_W)'({$urandom, $urandom});
            req_mode  = (NCH*2)'($urandom);
            cycle();
        end
        idle(4);

        put(0, 13'h1FFF, 2'd1); cycle();
        put(0, 13'h07FF, 2'd0); cycle();
        put(0, 13'h1FFF, 2'd3); cycle();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
